// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive/transmit state encoding, data width,
// the default bit timing and the memory-mapped register addresses.
package uart_pkg;

    // Frame-level states shared by the receiver and the transmitter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Payload bits per frame (8N1)
    localparam int UART_DATA_W = 8;

    // 100 MHz system clock at 115200 baud
    localparam int UART_CLKS_PER_BIT_DEF = 868;

    // Core-visible register map
    localparam logic [31:0] UART_TX_ADDR      = 32'hFFFF_FFFC;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'hFFFF_FFF4;

endpackage : uart_pkg

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO. The head word, empty and full are registered
// from next-state values so they change one cycle after the push/pop edge.
// A push into a full FIFO is only accepted when a pop happens in the same cycle;
// otherwise the word is dropped and overflow_o flags it for that cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] rdata_q;
    logic             empty_q;
    logic             full_q;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Accept/reject decisions, next pointers/count and the next head word
    always_comb begin
        pop_ok_s   = pop_i && (count_q != {CW{1'b0}});
        push_ok_s  = push_i && ((count_q != DEPTH_C) || pop_ok_s);
        overflow_o = push_i && (count_q == DEPTH_C) && !pop_i;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // The word being written this cycle becomes the head when it lands
        // in the slot the read pointer is about to point at.
        if (count_d == {CW{1'b0}}) begin
            head_d = {WIDTH{1'b0}};
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array write; contents are only ever exposed through head_d
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, count and registered status/head update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            rdata_q  <= {WIDTH{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= head_d;
            empty_q  <= (count_d == {CW{1'b0}});
            full_q   <= (count_d == DEPTH_C);
        end
    end

    assign rdata_o = rdata_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule : rx_fifo

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is double-flopped, a frame FSM finds the
// middle of the start bit and then samples each following bit one bit period
// apart. Completed bytes go into a show-ahead FIFO drained by the core;
// framing and overrun errors are sticky until errClr.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sIn,
    input  logic                   dataRen,
    input  logic                   errClr,
    output logic [UART_DATA_W-1:0] data,
    output logic                   fifoEmpty,
    output logic                   fifoFull,
    output logic                   frameErr,
    output logic                   overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CYC_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [CW-1:0] CYC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]             sync_q;
    logic                   rx_s;
    uart_state_e            state_q;
    logic [CW-1:0]          cyc_q;
    logic [2:0]             bit_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   stop_sample_s;
    logic                   push_s;
    logic                   ferr_set_s;
    logic                   fifo_ovf_s;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sIn};
        end
    end

    assign rx_s = sync_q[1];

    // Frame FSM: start detect, mid-start check, data bit sampling, stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= CYC_ZERO;
            bit_q   <= 3'd0;
            shift_q <= {UART_DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    cyc_q <= CYC_ZERO;
                    if (!rx_s) begin
                        state_q <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    if (cyc_q == CYC_HALF) begin
                        cyc_q <= CYC_ZERO;
                        bit_q <= 3'd0;
                        // A line that is high again by mid start bit was a glitch
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_ONE;
                    end
                end
                DATA: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_q          <= CYC_ZERO;
                        shift_q[bit_q] <= rx_s;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_ONE;
                    end
                end
                STOP: begin
                    // The stop bit itself is evaluated combinationally below;
                    // the FSM only has to return to IDLE at the sample point.
                    if (cyc_q == CYC_LAST) begin
                        cyc_q   <= CYC_ZERO;
                        state_q <= IDLE;
                    end else begin
                        cyc_q <= cyc_q + CYC_ONE;
                    end
                end
                default: begin
                    cyc_q   <= CYC_ZERO;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The byte is pushed in the same cycle the stop bit is sampled
    always_comb begin
        stop_sample_s = (state_q == STOP) && (cyc_q == CYC_LAST);
        push_s        = stop_sample_s && rx_s;
        ferr_set_s    = stop_sample_s && !rx_s;
    end

    rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (push_s),
        .wdata_i    (shift_q),
        .pop_i      (dataRen),
        .rdata_o    (data),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .overflow_o (fifo_ovf_s)
    );

    // Sticky error flags; a set event in the same cycle as errClr wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ferr_set_s) begin
                frame_err_q <= 1'b1;
            end else if (errClr) begin
                frame_err_q <= 1'b0;
            end else begin
                frame_err_q <= frame_err_q;
            end

            if (fifo_ovf_s) begin
                overrun_q <= 1'b1;
            end else if (errClr) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end
        end
    end

    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLKS_PER_BIT=16 and FIFO_DEPTH=4. A queue-based
// model tracks which bytes the receiver must hold and which sticky flags must
// be set; all stimulus and sampling happen on falling clock edges.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       sIn;
    logic       dataRen;
    logic       errClr;
    logic [7:0] data;
    logic       fifoEmpty;
    logic       fifoFull;
    logic       frameErr;
    logic       overrun;

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic       m_ferr;
    logic       m_ovr;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sIn       (sIn),
        .dataRen   (dataRen),
        .errClr    (errClr),
        .data      (data),
        .fifoEmpty (fifoEmpty),
        .fifoFull  (fifoFull),
        .frameErr  (frameErr),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line-level frame: start, 8 data bits LSB first, stop. Called at a falling edge.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        sIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sIn = b[i];
            repeat (CPB) @(negedge clk);
        end
        sIn = stop_bit;
        repeat (CPB) @(negedge clk);
        sIn = 1'b1;
    endtask

    // Reference: what one received frame does to the buffered bytes and flags
    task automatic model_rx(input logic [7:0] b, input logic stop_bit, input logic pop_same);
        if (!stop_bit) begin
            m_ferr = 1'b1;
            if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() < DEPTH) begin
            if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(b);
        end else if (pop_same) begin
            void'(exp_q.pop_front());
            exp_q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic pulse_pop();
        dataRen = 1'b1;
        @(negedge clk);
        dataRen = 1'b0;
    endtask

    task automatic pulse_clr();
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want %h", data, 8'h00); end
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", fifoEmpty); end
        checks++; if (fifoFull !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", fifoFull); end
        checks++; if (frameErr !== 1'b0) begin failures++; $display("FAIL reset_frameErr: got %b want 0", frameErr); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_latency();
        int lat;
        lat = -1;
        @(negedge clk);
        fork
            drive_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 200; n++) begin
                    @(negedge clk);
                    if (fifoEmpty == 1'b0) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        model_rx(8'hA5, 1'b1, 1'b0);
        // 9.5 bit periods plus the synchronizer, a few cycles of slack
        checks++;
        if (lat < (CPB * 19) / 2 + 1 || lat > (CPB * 19) / 2 + 5) begin
            failures++; $display("FAIL latency: got %0d cycles want %0d..%0d", lat, (CPB * 19) / 2 + 1, (CPB * 19) / 2 + 5);
        end
        checks++; if (data !== exp_q[0]) begin failures++; $display("FAIL single_data: got %h want %h", data, exp_q[0]); end
        pulse_pop();
        void'(exp_q.pop_front());
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL single_empty_after_pop: got %b want 1", fifoEmpty); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL single_data_after_pop: got %h want 00", data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [5];
        seq[0] = 8'h3C; seq[1] = 8'h00; seq[2] = 8'hFF; seq[3] = 8'h81; seq[4] = 8'h55;
        // A pop on an empty FIFO must be harmless
        @(negedge clk);
        pulse_pop();
        checks++; if (fifoEmpty !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL pop_empty: empty=%b overrun=%b want 1 0", fifoEmpty, overrun); end
        for (int i = 0; i < 5; i++) begin
            drive_frame(seq[i], 1'b1);
            model_rx(seq[i], 1'b1, 1'b0);
        end
        checks++; if (fifoFull !== 1'b1) begin failures++; $display("FAIL b2b_full: got %b want 1", fifoFull); end
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL b2b_overrun: got %b want %b", overrun, m_ovr); end
        while (exp_q.size() > 0) begin
            checks++;
            if (fifoEmpty !== 1'b0 || data !== exp_q[0]) begin
                failures++; $display("FAIL b2b_pop: got empty=%b data=%h want empty=0 data=%h", fifoEmpty, data, exp_q[0]);
            end
            pulse_pop();
            void'(exp_q.pop_front());
        end
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL b2b_drained: got %b want 1", fifoEmpty); end
        pulse_clr();
        m_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_frame_error();
        @(negedge clk);
        drive_frame(8'h12, 1'b0);
        model_rx(8'h12, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (frameErr !== m_ferr) begin failures++; $display("FAIL frame_err_set: got %b want %b", frameErr, m_ferr); end
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL frame_err_nopush: got %b want 1", fifoEmpty); end
        pulse_clr();
        m_ferr = 1'b0;
        checks++; if (frameErr !== 1'b0) begin failures++; $display("FAIL frame_err_clear: got %b want 0", frameErr); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        @(negedge clk);
        sIn = 1'b0;
        repeat (4) @(negedge clk);
        sIn = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (fifoEmpty !== 1'b1 || frameErr !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL glitch: empty=%b frameErr=%b overrun=%b want 1 0 0", fifoEmpty, frameErr, overrun);
        end
        // The receiver must be back in idle and take a normal frame
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        model_rx(b, 1'b1, 1'b0);
        checks++; if (fifoEmpty !== 1'b0 || data !== exp_q[0]) begin failures++; $display("FAIL glitch_after: got empty=%b data=%h want 0 %h", fifoEmpty, data, exp_q[0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] c3;
        c3 = 8'hC3;
        // FIFO holds a byte from the previous test; reset must discard it
        @(negedge clk);
        sIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sIn = c3[i];
            repeat (CPB) @(negedge clk);
        end
        sIn = c3[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (fifoEmpty !== 1'b1 || data !== 8'h00) begin failures++; $display("FAIL async_reset: got empty=%b data=%h want 1 00", fifoEmpty, data); end
        sIn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        repeat (CPB) @(negedge clk);
        drive_frame(8'h7E, 1'b1);
        model_rx(8'h7E, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (data !== exp_q[0] || fifoEmpty !== 1'b0) begin failures++; $display("FAIL reset_resume_data: got %h empty=%b want %h 0", data, fifoEmpty, exp_q[0]); end
        checks++; if (frameErr !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_resume_flags: got %b %b want 0 0", frameErr, overrun); end
        pulse_pop();
        void'(exp_q.pop_front());
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL reset_resume_single: got %b want 1", fifoEmpty); end
    endtask

    task automatic test_pop_on_stop();
        logic [7:0] b;
        logic [7:0] head_seen;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1);
            model_rx(b, 1'b1, 1'b0);
        end
        checks++; if (fifoFull !== 1'b1) begin failures++; $display("FAIL pos_prefull: got %b want 1", fifoFull); end
        head_seen = 8'h00;
        // Stop bit is sampled 9.5 bit periods plus 2 sync cycles after the start edge
        fork
            drive_frame(8'h99, 1'b1);
            begin
                repeat ((CPB * 19) / 2 + 2) @(negedge clk);
                head_seen = data;
                dataRen = 1'b1;
                @(negedge clk);
                dataRen = 1'b0;
            end
        join
        checks++; if (head_seen !== exp_q[0]) begin failures++; $display("FAIL pos_head: got %h want %h", head_seen, exp_q[0]); end
        model_rx(8'h99, 1'b1, 1'b1);
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL pos_overrun: got %b want %b", overrun, m_ovr); end
        checks++; if (fifoFull !== 1'b1) begin failures++; $display("FAIL pos_full: got %b want 1", fifoFull); end
        while (exp_q.size() > 0) begin
            checks++;
            if (fifoEmpty !== 1'b0 || data !== exp_q[0]) begin
                failures++; $display("FAIL pos_pop: got empty=%b data=%h want empty=0 data=%h", fifoEmpty, data, exp_q[0]);
            end
            pulse_pop();
            void'(exp_q.pop_front());
        end
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL pos_drained: got %b want 1", fifoEmpty); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        @(negedge clk);
        for (int f = 0; f < 24; f++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1);
            model_rx(b, 1'b1, 1'b0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            checks++;
            if (fifoFull !== (exp_q.size() == DEPTH)) begin
                failures++; $display("FAIL rnd_full: got %b want %b", fifoFull, (exp_q.size() == DEPTH));
            end
            while (exp_q.size() > 0 && (exp_q.size() == DEPTH || $urandom_range(0, 1) == 1)) begin
                checks++;
                if (fifoEmpty !== 1'b0 || data !== exp_q[0]) begin
                    failures++; $display("FAIL rnd_pop: got empty=%b data=%h want empty=0 data=%h", fifoEmpty, data, exp_q[0]);
                end
                pulse_pop();
                void'(exp_q.pop_front());
            end
        end
        while (exp_q.size() > 0) begin
            checks++;
            if (data !== exp_q[0]) begin failures++; $display("FAIL rnd_drain: got %h want %h", data, exp_q[0]); end
            pulse_pop();
            void'(exp_q.pop_front());
        end
        checks++; if (fifoEmpty !== 1'b1) begin failures++; $display("FAIL rnd_empty: got %b want 1", fifoEmpty); end
        checks++; if (frameErr !== m_ferr || overrun !== m_ovr) begin failures++; $display("FAIL rnd_flags: got %b %b want %b %b", frameErr, overrun, m_ferr, m_ovr); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;
        rst      = 1'b0;
        sIn      = 1'b1;
        dataRen  = 1'b0;
        errClr   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_latency();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_pop_on_stop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
